// File: rtl/pb_duty_ctrl.sv
// rtl/pb_duty_ctrl.sv - push-button duty-cycle controller with debounce, auto-repeat and clamping

module pb_debounce #(
  parameter int unsigned CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_n_i,
  output logic level_o
);

  localparam int unsigned CW = $clog2(CYCLES + 1);

  logic [1:0]    sync_q;
  logic          pressed;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], pb_n_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pressed = ~sync_q[1];

  // Counter only advances while the synchronized level disagrees; any agreement restarts it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (pressed != level_q) begin
      if (cnt_q == CW'(CYCLES - 1)) begin
        level_d = pressed;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;

endmodule

module pb_duty_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_RATE     = 10_000_000,
  parameter int unsigned DC_INIT         = 25_000,
  parameter int unsigned DC_STEP         = 5_000,
  parameter int unsigned DC_MIN          = 5_000,
  parameter int unsigned DC_MAX          = 150_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pb_inc,
  input  logic        pb_dec,
  output logic [31:0] duty,
  output logic        step_pulse,
  output logic        limit_hit
);

  localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam logic [1:0] ST_LOCK   = 2'd3;

  logic inc_lvl, dec_lvl;
  logic inc_prev_q, dec_prev_q;
  logic inc_rise, dec_rise, both_held, active_held, expire;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          dir_q, dir_d;
  logic          step_req, step_up;

  logic [31:0] duty_q, duty_d;
  logic        step_q, step_d;
  logic        limit_q, limit_d;
  logic [32:0] sum, diff;
  logic [31:0] nxt;

  pb_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk     (clk),
    .rst     (rst),
    .pb_n_i  (pb_inc),
    .level_o (inc_lvl)
  );

  pb_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
    .clk     (clk),
    .rst     (rst),
    .pb_n_i  (pb_dec),
    .level_o (dec_lvl)
  );

  assign inc_rise    = inc_lvl & ~inc_prev_q;
  assign dec_rise    = dec_lvl & ~dec_prev_q;
  assign both_held   = inc_lvl & dec_lvl;
  assign active_held = dir_q ? inc_lvl : dec_lvl;
  assign expire      = (timer_q <= TW'(1));

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    dir_d    = dir_q;
    step_req = 1'b0;
    step_up  = dir_q;
    if (both_held) begin
      state_d = ST_LOCK;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (inc_rise ^ dec_rise) begin
            step_req = 1'b1;
            step_up  = inc_rise;
            dir_d    = inc_rise;
            timer_d  = TW'(REPEAT_DELAY);
            state_d  = ST_DELAY;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (!active_held) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else if (expire) begin
            step_req = 1'b1;
            timer_d  = TW'(REPEAT_RATE);
            state_d  = ST_REPEAT;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_LOCK: begin
          if (!inc_lvl && !dec_lvl) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // 33-bit headroom keeps the add/subtract from wrapping before the clamp.
  always_comb begin
    sum  = {1'b0, duty_q} + 33'(DC_STEP);
    diff = {1'b0, duty_q} - 33'(DC_STEP);
    if (step_up) begin
      nxt = (sum > 33'(DC_MAX)) ? 32'(DC_MAX) : sum[31:0];
    end else begin
      nxt = (diff[32] || diff < 33'(DC_MIN)) ? 32'(DC_MIN) : diff[31:0];
    end
    duty_d  = duty_q;
    step_d  = 1'b0;
    limit_d = 1'b0;
    if (step_req) begin
      if (nxt == duty_q) begin
        limit_d = 1'b1;
      end else begin
        duty_d = nxt;
        step_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      dir_q      <= 1'b0;
      inc_prev_q <= 1'b0;
      dec_prev_q <= 1'b0;
      duty_q     <= 32'(DC_INIT);
      step_q     <= 1'b0;
      limit_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      dir_q      <= dir_d;
      inc_prev_q <= inc_lvl;
      dec_prev_q <= dec_lvl;
      duty_q     <= duty_d;
      step_q     <= step_d;
      limit_q    <= limit_d;
    end
  end

  assign duty       = duty_q;
  assign step_pulse = step_q;
  assign limit_hit  = limit_q;

endmodule

// File: tb/tb_pb_duty_ctrl.sv
// tb/tb_pb_duty_ctrl.sv - self-checking bench for pb_duty_ctrl against an event-level duty model

module tb_pb_duty_ctrl;

  localparam int DB      = 4;
  localparam int RD      = 20;
  localparam int RR      = 8;
  localparam int DC_INIT = 25_000;
  localparam int DC_STEP = 5_000;
  localparam int DC_MIN  = 5_000;
  localparam int DC_MAX  = 150_000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pb_inc;
  logic        pb_dec;
  logic [31:0] duty;
  logic        step_pulse;
  logic        limit_hit;

  int n_checks = 0;
  int n_errors = 0;
  int m_duty;

  always #5 clk = ~clk;

  pb_duty_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pb_inc     (pb_inc),
    .pb_dec     (pb_dec),
    .duty       (duty),
    .step_pulse (step_pulse),
    .limit_hit  (limit_hit)
  );

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input bit pulse, input bit lim);
    check("duty", {1'b0, duty}, 33'(m_duty));
    check("step_pulse", 33'(step_pulse), 33'(pulse));
    check("limit_hit", 33'(limit_hit), 33'(lim));
  endtask

  // rel: edges since the first sampled low; h_rel: number of low samples from that origin.
  function automatic bit step_due(input int rel, input int h_rel);
    if (h_rel < DB) return 1'b0;
    if (rel > h_rel + DB + 1) return 1'b0;
    if (rel == DB + 2) return 1'b1;
    if (rel >= DB + 2 + RD && ((rel - (DB + 2 + RD)) % RR) == 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_press(input bit up, input int h, input int gap, input int rst_at);
    for (int t = 0; t < h + gap; t++) begin
      bit pulse;
      bit lim;
      int o;
      int nxt;
      rst = (t == rst_at);
      if (up) pb_inc = (t >= h);
      else    pb_dec = (t >= h);
      @(posedge clk);
      #1;
      pulse = 1'b0;
      lim   = 1'b0;
      if (t == rst_at) begin
        m_duty = DC_INIT;
      end else begin
        o = (rst_at >= 0 && t > rst_at) ? rst_at + 1 : 0;
        if (step_due(t - o, h - o)) begin
          if (up) nxt = (m_duty + DC_STEP > DC_MAX) ? DC_MAX : m_duty + DC_STEP;
          else    nxt = (m_duty < DC_MIN + DC_STEP) ? DC_MIN : m_duty - DC_STEP;
          if (nxt == m_duty) lim = 1'b1;
          else begin
            pulse  = 1'b1;
            m_duty = nxt;
          end
        end
      end
      check_outputs(pulse, lim);
    end
    rst = 1'b0;
  endtask

  initial begin
    bit up;
    int h;
    int r;
    rst    = 1'b1;
    pb_inc = 1'b1;
    pb_dec = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_duty = DC_INIT;
    check_outputs(1'b0, 1'b0);
    rst = 1'b0;

    run_press(1'b1, 3, 10, -1);
    run_press(1'b1, 40, 10, -1);
    run_press(1'b1, 230, 10, -1);
    run_press(1'b1, 5, 10, -1);
    run_press(1'b0, 250, 10, -1);
    run_press(1'b1, 5, 10, -1);
    run_press(1'b0, 5, 10, -1);
    run_press(1'b0, 5, 10, -1);

    for (int t = 0; t < 112; t++) begin
      pb_inc = (t >= 100);
      pb_dec = (t >= 100);
      @(posedge clk);
      #1;
      check_outputs(1'b0, 1'b0);
    end
    run_press(1'b0, 5, 10, -1);
    run_press(1'b1, 60, 10, 40);

    for (int i = 0; i < 20; i++) begin
      up = ($urandom_range(0, 1) == 1);
      h  = $urandom_range(1, 70);
      r  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, h - 1) : -1;
      run_press(up, h, 10, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
